// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller.
// Holds the controller state encoding and the EX forwarding select codes.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        MEM_WAIT = 2'b10,
        FAULT    = 2'b11
    } ctrl_state_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational load-use hazard detection and EX operand forwarding selects.
// Ports: ID/EX/MEM/WB register indices and write flags in; luhaz, fwd_a, fwd_b out.
module hazard_fwd_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] ex_wReg,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] mem_wReg,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] wb_wReg,
    input  logic             wb_reg_write,
    output logic             luhaz,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);

    // MEM is the younger producer, so it wins over WB.
    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
        if (mem_reg_write && mem_wReg != '0 && mem_wReg == src)
            return FWD_MEM;
        else if (wb_reg_write && wb_wReg != '0 && wb_wReg == src)
            return FWD_WB;
        else
            return FWD_REG;
    endfunction

    logic ex_load;

    assign ex_load = ex_mem_read && ex_reg_write && ex_wReg != '0;

    assign luhaz = ex_load &&
                   (ex_wReg == id_rs || (id_uses_rt && ex_wReg == id_rt));

    assign fwd_a = fwd_sel(ex_rs);
    assign fwd_b = fwd_sel(ex_rt);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, branch flush, memory freeze.
// Ports: hazard/handshake inputs in; stage enables, flush/bubble, fwd selects, stall_cnt, fault out.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] ex_wReg,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] mem_wReg,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] wb_wReg,
    input  logic             wb_reg_write,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_write,
    output logic             memwb_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             fault
);

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_TOP = WAIT_W'(TIMEOUT - 1);

    ctrl_state_t       state, nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_inc;
    logic              memstall;
    logic              luhaz;
    logic [1:0]        fwd_a_raw, fwd_b_raw;

    hazard_fwd_unit #(.REG_W(REG_W)) u_hfu (
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .ex_wReg       (ex_wReg),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .mem_wReg      (mem_wReg),
        .mem_reg_write (mem_reg_write),
        .wb_wReg       (wb_wReg),
        .wb_reg_write  (wb_reg_write),
        .luhaz         (luhaz),
        .fwd_a         (fwd_a_raw),
        .fwd_b         (fwd_b_raw)
    );

    assign memstall = dmem_req && !dmem_ready;

    // Outputs fall back to RUN idle values while reset is held.
    assign fwd_a = rst_n ? fwd_a_raw : FWD_REG;
    assign fwd_b = rst_n ? fwd_b_raw : FWD_REG;

    always_comb begin
        nxt          = state;
        wait_inc     = 1'b0;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_write  = 1'b1;
        memwb_bubble = 1'b0;
        if (rst_n) begin
            unique case (state)
                RUN: begin
                    if (memstall) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        exmem_write  = 1'b0;
                        memwb_bubble = 1'b1;
                        nxt          = MEM_WAIT;
                    end else if (luhaz) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        nxt         = LU_STALL;
                    end else begin
                        ifid_flush = branch_taken;
                    end
                end
                LU_STALL: begin
                    if (memstall) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        exmem_write  = 1'b0;
                        memwb_bubble = 1'b1;
                        nxt          = MEM_WAIT;
                    end else begin
                        ifid_flush = branch_taken;
                        nxt        = RUN;
                    end
                end
                MEM_WAIT: begin
                    if (memstall) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        exmem_write  = 1'b0;
                        memwb_bubble = 1'b1;
                        if (wait_cnt == WAIT_TOP)
                            nxt = FAULT;
                        else
                            wait_inc = 1'b1;
                    end else begin
                        nxt = RUN;
                    end
                end
                FAULT: begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    exmem_write  = 1'b0;
                    memwb_bubble = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            fault     <= 1'b0;
        end else begin
            state <= nxt;
            if (state != MEM_WAIT && nxt == MEM_WAIT)
                wait_cnt <= '0;
            else if (wait_inc)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (!pc_write && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (nxt == FAULT)
                fault <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
// Drives stall, flush, memory-wait, timeout and forwarding scenarios.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_wReg, mem_wReg, wb_wReg;
    logic        id_uses_rt, ex_reg_write, ex_mem_read;
    logic        mem_reg_write, wb_reg_write;
    logic        branch_taken, dmem_req, dmem_ready;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble;
    logic        exmem_write, memwb_bubble, fault;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .ex_wReg       (ex_wReg),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .mem_wReg      (mem_wReg),
        .mem_reg_write (mem_reg_write),
        .wb_wReg       (wb_wReg),
        .wb_reg_write  (wb_reg_write),
        .branch_taken  (branch_taken),
        .dmem_req      (dmem_req),
        .dmem_ready    (dmem_ready),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .ifid_flush    (ifid_flush),
        .idex_bubble   (idex_bubble),
        .exmem_write   (exmem_write),
        .memwb_bubble  (memwb_bubble),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .stall_cnt     (stall_cnt),
        .fault         (fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_rs = 0; id_rt = 0; id_uses_rt = 0;
        ex_rs = 0; ex_rt = 0; ex_wReg = 0;
        ex_reg_write = 0; ex_mem_read = 0;
        mem_wReg = 0; mem_reg_write = 0;
        wb_wReg = 0; wb_reg_write = 0;
        branch_taken = 0; dmem_req = 0; dmem_ready = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_in();
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic set_load(input logic [4:0] rd);
        ex_mem_read = 1; ex_reg_write = 1; ex_wReg = rd;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_in();
        #3;
        chk("rst_pc_write", pc_write, 1);
        chk("rst_ifid_write", ifid_write, 1);
        chk("rst_exmem_write", exmem_write, 1);
        chk("rst_flush", ifid_flush, 0);
        chk("rst_idex_bubble", idex_bubble, 0);
        chk("rst_memwb_bubble", memwb_bubble, 0);
        chk("rst_fwd", {fwd_a, fwd_b}, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_fault", fault, 0);
        rst_n = 1'b1;
        tick();

        // load-use on rs
        set_load(5); id_rs = 5;
        #2;
        chk("lu_pc_write", pc_write, 0);
        chk("lu_ifid_write", ifid_write, 0);
        chk("lu_idex_bubble", idex_bubble, 1);
        chk("lu_exmem_write", exmem_write, 1);
        tick();
        clear_in();
        #2;
        chk("lus_pc_write", pc_write, 1);
        chk("lus_idex_bubble", idex_bubble, 0);
        chk("lus_stall_cnt", stall_cnt, 1);
        tick();
        chk("lu_done_cnt", stall_cnt, 1);

        // r0 never hazards; rt only when used
        set_load(0); id_rs = 0;
        #2;
        chk("lu_r0", pc_write, 1);
        set_load(6); id_rt = 6; id_uses_rt = 0;
        #2;
        chk("lu_rt_unused", pc_write, 1);
        id_uses_rt = 1;
        #2;
        chk("lu_rt_used", idex_bubble, 1);
        tick();
        clear_in();
        tick();

        // branch flush
        branch_taken = 1;
        #2;
        chk("br_flush", ifid_flush, 1);
        chk("br_pc_write", pc_write, 1);
        tick();
        branch_taken = 0;
        #2;
        chk("br_flush_off", ifid_flush, 0);

        // load-use beats branch, branch honoured in LU_STALL
        set_load(9); id_rs = 9; branch_taken = 1;
        #2;
        chk("pri_no_flush", ifid_flush, 0);
        chk("pri_stall", pc_write, 0);
        tick();
        ex_mem_read = 0; ex_reg_write = 0; ex_wReg = 0;
        #2;
        chk("pri_lus_flush", ifid_flush, 1);
        chk("pri_lus_pc", pc_write, 1);
        tick();
        clear_in();

        // memory wait of three cycles
        do_reset();
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("mw_pc_write", pc_write, 0);
            chk("mw_ifid_write", ifid_write, 0);
            chk("mw_exmem_write", exmem_write, 0);
            chk("mw_memwb_bubble", memwb_bubble, 1);
            tick();
        end
        dmem_ready = 1;
        #2;
        chk("mw_rel_pc", pc_write, 1);
        chk("mw_rel_exmem", exmem_write, 1);
        chk("mw_rel_bubble", memwb_bubble, 0);
        tick();
        clear_in();
        #2;
        chk("mw_stall_cnt", stall_cnt, 3);

        // timeout to sticky fault
        do_reset();
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 63; i++) tick();
        chk("to_no_fault_yet", fault, 0);
        chk("to_freeze", pc_write, 0);
        for (int i = 0; i < 3; i++) tick();
        chk("to_fault", fault, 1);
        set_load(4); id_rs = 4; branch_taken = 1; dmem_ready = 1;
        #2;
        chk("to_hold_pc", pc_write, 0);
        chk("to_hold_exmem", exmem_write, 0);
        chk("to_ign_flush", ifid_flush, 0);
        chk("to_ign_bubble", idex_bubble, 0);
        chk("to_stall_cnt", stall_cnt, 66);
        tick();
        chk("to_fault_sticky", fault, 1);
        rst_n = 1'b0;
        #1;
        chk("to_rst_fault", fault, 0);
        chk("to_rst_pc", pc_write, 1);
        chk("to_rst_flush", ifid_flush, 0);
        chk("to_rst_cnt", stall_cnt, 0);
        clear_in();
        #2;
        rst_n = 1'b1;
        tick();

        // forwarding
        mem_wReg = 7; wb_wReg = 7; ex_rs = 7;
        mem_reg_write = 1; wb_reg_write = 1;
        #2;
        chk("fwd_a_mem", fwd_a, 2'b10);
        chk("fwd_b_none", fwd_b, 2'b00);
        mem_reg_write = 0;
        #2;
        chk("fwd_a_wb", fwd_a, 2'b01);
        mem_reg_write = 1;
        mem_wReg = 0; wb_wReg = 0; ex_rs = 0;
        #2;
        chk("fwd_a_r0", fwd_a, 2'b00);
        ex_rt = 3; mem_wReg = 3; wb_wReg = 3;
        #2;
        chk("fwd_b_mem", fwd_b, 2'b10);
        mem_wReg = 4;
        #2;
        chk("fwd_b_wb", fwd_b, 2'b01);
        wb_reg_write = 0;
        #2;
        chk("fwd_b_none2", fwd_b, 2'b00);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
